// File: rtl/mmio_bus_matrix.sv
// Single-master MMIO crossbar: decodes one request to a slave, holds it until
// that slave reports ready, then returns a one-cycle response pulse.
// Optional ACCESS watchdog: define MMIO_BUS_MATRIX_TIMEOUT_EN.
module mmio_bus_matrix #(
  parameter int                          NUM_SLAVES     = 4,
  parameter int                          DATA_W         = 32,
  parameter logic [NUM_SLAVES*32-1:0]    SLV_BASE       = {32'ha0000100, 32'ha0000000,
                                                           32'h10010000, 32'h90000000},
  parameter logic [NUM_SLAVES*32-1:0]    SLV_MASK       = {4{32'hffffff00}},
  parameter int                          TIMEOUT_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  m_address,
  input  logic [DATA_W-1:0]            m_write_data,
  input  logic [DATA_W/8-1:0]          m_write_mask,
  input  logic                         m_write_enable,
  input  logic                         m_read_enable,
  output logic                         m_busy,
  output logic                         m_resp_valid,
  output logic                         m_error,
  output logic [DATA_W-1:0]            m_read_data,
  output logic [NUM_SLAVES-1:0]        s_sel,
  output logic [31:0]                  s_address,
  output logic [DATA_W-1:0]            s_write_data,
  output logic [DATA_W/8-1:0]          s_write_mask,
  output logic                         s_write_enable,
  output logic                         s_read_enable,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_read_data,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  output logic [7:0]                   err_count
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state, state_next;
  logic                  req, req_both;
  logic [NUM_SLAVES-1:0] hit_vec, hit_sel;
  logic                  sel_ready;
  logic [DATA_W-1:0]     sel_rdata;
  logic                  timeout_hit;
  logic                  access_done;

  assign req       = m_write_enable | m_read_enable;
  assign req_both  = m_write_enable & m_read_enable;
  assign sel_ready = |(s_sel & s_ready);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hit_vec = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      hit_vec[k] = (m_address & SLV_MASK[k*32 +: 32]) ==
                   (SLV_BASE[k*32 +: 32] & SLV_MASK[k*32 +: 32]);
    end
  end

  // Isolating the lowest set bit gives lowest-index priority on overlapping windows.
  assign hit_sel = hit_vec & ((~hit_vec) + NUM_SLAVES'(1));

  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (s_sel[k]) sel_rdata = sel_rdata | s_read_data[k*DATA_W +: DATA_W];
    end
  end

`ifdef MMIO_BUS_MATRIX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] access_cnt;

  assign timeout_hit = (state == ACCESS) && !sel_ready &&
                       (access_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      access_cnt <= '0;
    end else if (state != ACCESS || sel_ready || timeout_hit) begin
      access_cnt <= '0;
    end else begin
      access_cnt <= access_cnt + CNT_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign access_done = (state == ACCESS) && (sel_ready || timeout_hit);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = (req_both || hit_vec == '0) ? RESP : ACCESS;
      ACCESS:  if (sel_ready || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign m_busy       = (state != IDLE);
  assign m_resp_valid = (state == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_error        <= 1'b0;
      m_read_data    <= '0;
      err_count      <= '0;
      s_sel          <= '0;
      s_address      <= '0;
      s_write_data   <= '0;
      s_write_mask   <= '0;
      s_write_enable <= 1'b0;
      s_read_enable  <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        if (!req_both && hit_vec != '0) begin
          s_sel          <= hit_sel;
          s_address      <= m_address;
          s_write_data   <= m_write_data;
          s_write_mask   <= m_write_mask;
          s_write_enable <= m_write_enable;
          s_read_enable  <= m_read_enable;
        end else begin
          m_error     <= 1'b1;
          m_read_data <= '0;
          if (err_count != 8'hff) err_count <= err_count + 8'd1;
        end
      end

      if (access_done) begin
        s_sel          <= '0;
        s_address      <= '0;
        s_write_data   <= '0;
        s_write_mask   <= '0;
        s_write_enable <= 1'b0;
        s_read_enable  <= 1'b0;
        if (sel_ready) begin
          m_error     <= 1'b0;
          m_read_data <= s_read_enable ? sel_rdata : '0;
        end else begin
          m_error     <= 1'b1;
          m_read_data <= '0;
          if (err_count != 8'hff) err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mmio_bus_matrix.sv
// Directed self-checking bench for mmio_bus_matrix (default 4-slave map).
module tb_mmio_bus_matrix;
  localparam int NUM_SLAVES = 4;
  localparam int DATA_W     = 32;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [31:0]                  m_address;
  logic [DATA_W-1:0]            m_write_data;
  logic [DATA_W/8-1:0]          m_write_mask;
  logic                         m_write_enable, m_read_enable;
  logic                         m_busy, m_resp_valid, m_error;
  logic [DATA_W-1:0]            m_read_data;
  logic [NUM_SLAVES-1:0]        s_sel;
  logic [31:0]                  s_address;
  logic [DATA_W-1:0]            s_write_data;
  logic [DATA_W/8-1:0]          s_write_mask;
  logic                         s_write_enable, s_read_enable;
  logic [NUM_SLAVES*DATA_W-1:0] s_read_data;
  logic [NUM_SLAVES-1:0]        s_ready;
  logic [7:0]                   err_count;

  int checks = 0;
  int errors = 0;

  mmio_bus_matrix dut (
    .clk(clk), .rst(rst),
    .m_address(m_address), .m_write_data(m_write_data), .m_write_mask(m_write_mask),
    .m_write_enable(m_write_enable), .m_read_enable(m_read_enable),
    .m_busy(m_busy), .m_resp_valid(m_resp_valid), .m_error(m_error), .m_read_data(m_read_data),
    .s_sel(s_sel), .s_address(s_address), .s_write_data(s_write_data),
    .s_write_mask(s_write_mask), .s_write_enable(s_write_enable), .s_read_enable(s_read_enable),
    .s_read_data(s_read_data), .s_ready(s_ready), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for exactly one edge; returns just after the accept edge.
  task automatic start(input logic [31:0] addr, input logic we, input logic re,
                       input logic [31:0] wd, input logic [3:0] wm);
    m_address      = addr;
    m_write_data   = wd;
    m_write_mask   = wm;
    m_write_enable = we;
    m_read_enable  = re;
    tick();
    m_write_enable = 1'b0;
    m_read_enable  = 1'b0;
  endtask

  // Edges from the accept edge to the edge that samples m_resp_valid high.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!m_resp_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  int lat;
  logic busy_ok;

  initial begin
    rst = 1'b1;
    m_address = '0; m_write_data = '0; m_write_mask = '0;
    m_write_enable = 1'b0; m_read_enable = 1'b0;
    s_read_data = '0; s_ready = '0;
    tick(); tick();
    check("rst_busy", m_busy, 0);
    check("rst_resp_valid", m_resp_valid, 0);
    check("rst_error", m_error, 0);
    check("rst_read_data", m_read_data, 0);
    check("rst_s_sel", s_sel, 0);
    check("rst_s_bus", {s_address, s_write_data, s_write_mask, s_write_enable, s_read_enable}, 0);
    check("rst_err_count", err_count, 0);
    rst = 1'b0;
    tick();

    // Read slave 0, ready on first ACCESS cycle.
    start(32'h9000_0010, 1'b0, 1'b1, 32'h0, 4'h0);
    check("rd0_busy", m_busy, 1);
    check("rd0_s_sel", s_sel, 4'b0001);
    check("rd0_s_addr", s_address, 32'h9000_0010);
    check("rd0_s_re", {s_read_enable, s_write_enable}, 2'b10);
    s_read_data[0*DATA_W +: DATA_W] = 32'h1234_5678;
    s_ready = 4'b0001;
    wait_resp(lat);
    s_ready = '0;
    check("rd0_latency", lat, 2);
    check("rd0_data", m_read_data, 32'h1234_5678);
    check("rd0_error", m_error, 0);
    check("rd0_s_sel_cleared", s_sel, 0);
    tick();
    check("rd0_pulse_one_cycle", m_resp_valid, 0);
    check("rd0_data_held", m_read_data, 32'h1234_5678);

    // Write slave 3, ready on third ACCESS cycle; foreign ready and busy strobes ignored.
    start(32'ha000_0100, 1'b1, 1'b0, 32'hdead_beef, 4'hf);
    s_ready = 4'b0001;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("wr3_s_sel_c%0d", c), s_sel, 4'b1000);
      check($sformatf("wr3_s_addr_c%0d", c), s_address, 32'ha000_0100);
      check($sformatf("wr3_busy_c%0d", c), {m_busy, m_resp_valid}, 2'b10);
      if (c == 1) begin
        m_address = 32'h9000_0000;
        m_read_enable = 1'b1;
      end
      if (c == 2) m_read_enable = 1'b0;
      if (c == 3) s_ready = 4'b1000;
      tick();
    end
    s_ready = '0;
    check("wr3_resp_valid", m_resp_valid, 1);
    check("wr3_error", m_error, 0);
    check("wr3_read_data_zero", m_read_data, 0);
    check("wr3_s_cleared", {s_sel, s_write_enable, s_write_data}, 0);
    tick();

    // Verify the latched payload reaches the slave bus.
    start(32'ha000_0104, 1'b1, 1'b0, 32'hdead_beef, 4'h5);
    check("wr3b_payload", {s_write_data, s_write_mask, s_write_enable}, {32'hdead_beef, 4'h5, 1'b1});
    s_ready = 4'b1000;
    wait_resp(lat);
    s_ready = '0;
    check("wr3b_latency", lat, 2);
    tick();

    // Unmapped read.
    start(32'h0000_0000, 1'b0, 1'b1, 32'h0, 4'h0);
    check("miss_s_sel", s_sel, 0);
    wait_resp(lat);
    check("miss_latency", lat, 1);
    check("miss_error", m_error, 1);
    check("miss_data", m_read_data, 0);
    check("miss_err_count", err_count, 1);
    tick();
    check("miss_error_held", {m_resp_valid, m_error}, 2'b01);

    // Both strobes on a mapped address.
    start(32'h9000_0000, 1'b1, 1'b1, 32'h0, 4'hf);
    check("both_s_sel", s_sel, 0);
    wait_resp(lat);
    check("both_latency", lat, 1);
    check("both_error", m_error, 1);
    check("both_err_count", err_count, 2);
    tick();

    // Read slave 1 with distinct data on every slice.
    s_read_data = {32'h3333_3333, 32'h2222_2222, 32'hcafe_f00d, 32'h1111_1111};
    start(32'h1001_0044, 1'b0, 1'b1, 32'h0, 4'h0);
    check("rd1_s_sel", s_sel, 4'b0010);
    s_ready = 4'b0010;
    wait_resp(lat);
    s_ready = '0;
    check("rd1_latency", lat, 2);
    check("rd1_data", m_read_data, 32'hcafe_f00d);
    check("rd1_error", m_error, 0);
    tick();

    // Slave 1 never ready.
    start(32'h1001_0000, 1'b0, 1'b1, 32'h0, 4'h0);
`ifdef MMIO_BUS_MATRIX_TIMEOUT_EN
    wait_resp(lat);
    check("to_latency", lat, 17);
    check("to_error", m_error, 1);
    check("to_data", m_read_data, 0);
    tick();
    start(32'h1001_0000, 1'b0, 1'b1, 32'h0, 4'h0);
    tick(); tick();
`else
    busy_ok = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (!(m_busy && s_sel == 4'b0010 && !m_resp_valid)) busy_ok = 1'b0;
      tick();
    end
    check("noto_busy_100", busy_ok, 1);
`endif

    // Asynchronous reset in the middle of ACCESS.
    check("arst_pre_busy", m_busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", m_busy, 0);
    check("arst_s_sel", s_sel, 0);
    check("arst_resp_valid", m_resp_valid, 0);
    check("arst_err_count", err_count, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("arst_no_resp", {m_resp_valid, m_busy}, 0);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      start(32'h0000_0000, 1'b0, 1'b1, 32'h0, 4'h0);
      tick();
      if (i == 253) check("sat_254", err_count, 254);
    end
    check("sat_255", err_count, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
